// File: rtl/simple_sram_2_pkg.sv
// Shared sizing constants, word/address types and depth helper for the systolic data buffer RAM.
// Optional build macro used by this block: SRAM_WR_BYPASS_EN (write-first forwarding on read ports).
package sram_pkg;

  localparam int SRAM_ADDR_W = 12;
  localparam int SRAM_DATA_W = 128;
  localparam int LANES       = 16;
  localparam int LANE_W      = 8;

  typedef logic [SRAM_DATA_W-1:0] sram_word_t;
  typedef logic [SRAM_ADDR_W-1:0] sram_addr_t;

  function automatic int sram_depth(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage

// File: rtl/simple_sram_2_if.sv
// Write port plus two read ports of the data buffer RAM grouped as one bus.
interface simple_sram_2_if #(
  parameter int AW = 12,
  parameter int DW = 128
);

  logic [AW-1:0] waddr;
  logic [AW-1:0] raddr_a;
  logic [AW-1:0] raddr_b;
  logic          write;
  logic [DW-1:0] din;
  logic [DW-1:0] dout_a;
  logic [DW-1:0] dout_b;

  modport master (
    output waddr, raddr_a, raddr_b, write, din,
    input  dout_a, dout_b
  );

  modport slave (
    input  waddr, raddr_a, raddr_b, write, din,
    output dout_a, dout_b
  );

endinterface

// File: rtl/simple_sram_2_read_port.sv
// One registered read port (1-cycle latency, sync reset to zero); with SRAM_WR_BYPASS_EN a
// same-address write is forwarded, otherwise the old word is returned (read-first).
module sram_read_port #(
  parameter int AW = 12,
  parameter int DW = 128
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] mem_rd_i,
`ifdef SRAM_WR_BYPASS_EN
  input  logic [AW-1:0] raddr_i,
  input  logic [AW-1:0] waddr_i,
  input  logic          write_i,
  input  logic [DW-1:0] din_i,
`endif
  output logic [DW-1:0] dout_o
);

  logic [DW-1:0] dout_d;
  logic [DW-1:0] dout_q;

  always_comb begin
    dout_d = mem_rd_i;
`ifdef SRAM_WR_BYPASS_EN
    if (write_i && (raddr_i == waddr_i)) begin
      dout_d = din_i;
    end
`endif
  end

  // Reset has priority, so a bypass can never leak out while rst is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout_q <= '0;
    end else begin
      dout_q <= dout_d;
    end
  end

  assign dout_o = dout_q;

endmodule

// File: rtl/simple_sram_2.sv
// Data buffer RAM: one synchronous write port, two independent registered read ports (A, B).
// Build macro SRAM_WR_BYPASS_EN selects write-first forwarding; default is read-first.
module simple_sram_2
  import sram_pkg::*;
#(
  parameter int addr_width = SRAM_ADDR_W,
  parameter int data_width = SRAM_DATA_W
) (
  input  logic            clk,
  input  logic            rst,
  simple_sram_2_if.slave  bus
);

  localparam int DEPTH = sram_depth(addr_width);

  // Contents are deliberately not reset; only the read registers are.
  logic [data_width-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (!rst && bus.write) begin
      mem_q[bus.waddr] <= bus.din;
    end
  end

  sram_read_port #(
    .AW (addr_width),
    .DW (data_width)
  ) u_rd_a (
    .clk      (clk),
    .rst      (rst),
    .mem_rd_i (mem_q[bus.raddr_a]),
`ifdef SRAM_WR_BYPASS_EN
    .raddr_i  (bus.raddr_a),
    .waddr_i  (bus.waddr),
    .write_i  (bus.write),
    .din_i    (bus.din),
`endif
    .dout_o   (bus.dout_a)
  );

  sram_read_port #(
    .AW (addr_width),
    .DW (data_width)
  ) u_rd_b (
    .clk      (clk),
    .rst      (rst),
    .mem_rd_i (mem_q[bus.raddr_b]),
`ifdef SRAM_WR_BYPASS_EN
    .raddr_i  (bus.raddr_b),
    .waddr_i  (bus.waddr),
    .write_i  (bus.write),
    .din_i    (bus.din),
`endif
    .dout_o   (bus.dout_b)
  );

endmodule

// File: tb/tb_simple_sram_2.sv
// Directed bench for simple_sram_2: reset, burst write/read, dual-port, read-during-write,
// boundary addresses and reset mid-burst, each compared against hand-computed words.
module tb_simple_sram_2;
  import sram_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  simple_sram_2_if #(.AW(SRAM_ADDR_W), .DW(SRAM_DATA_W)) bus ();

  simple_sram_2 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input sram_word_t obs, input sram_word_t exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs set before the call are sampled on the next edge; outputs read 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic sram_word_t lane_fill(input int v);
    logic [7:0] b;
    b = v[7:0];
    return {16{b}};
  endfunction

  sram_word_t ones_w;
  sram_word_t w_aa;
  sram_word_t w_55;
  sram_word_t w_hi;
  sram_word_t w_lo;
  sram_word_t w_3c;
  sram_word_t exp_a;

  initial begin
    checks   = 0;
    failures = 0;
    ones_w   = '1;
    w_aa     = {16{8'hAA}};
    w_55     = {16{8'h55}};
    w_hi     = {2{64'h0123_4567_89AB_CDEF}};
    w_lo     = {2{64'hFEDC_BA98_7654_3210}};
    w_3c     = {16{8'h3C}};

    // T1: reset with a write held active; write must be suppressed.
    rst         = 1'b1;
    bus.write   = 1'b1;
    bus.waddr   = '0;
    bus.din     = ones_w;
    bus.raddr_a = '0;
    bus.raddr_b = '0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t1_rst_dout_a", bus.dout_a, '0);
      check("t1_rst_dout_b", bus.dout_b, '0);
    end
    rst       = 1'b0;
    bus.write = 1'b0;
    tick();
    checks++;
    assert (bus.dout_a !== ones_w) else begin
      failures++;
      $error("FAIL t1_addr0_not_written observed=%h expected=not_all_ones", bus.dout_a);
    end

    // T2: back-to-back burst write of 64 words, then sweep both ports.
    for (int i = 0; i < 64; i++) begin
      bus.write = 1'b1;
      bus.waddr = SRAM_ADDR_W'(i);
      bus.din   = lane_fill(i);
      tick();
    end
    bus.write = 1'b0;
    for (int i = 0; i < 64; i++) begin
      bus.raddr_a = SRAM_ADDR_W'(i);
      bus.raddr_b = SRAM_ADDR_W'(63 - i);
      tick();
      check("t2_burst_a", bus.dout_a, lane_fill(i));
      check("t2_burst_b", bus.dout_b, lane_fill(63 - i));
    end

    // T3: independent addresses, then the same address on both ports.
    bus.raddr_a = 12'd5;
    bus.raddr_b = 12'd60;
    tick();
    check("t3_indep_a", bus.dout_a, lane_fill(5));
    check("t3_indep_b", bus.dout_b, lane_fill(60));
    bus.raddr_a = 12'd7;
    bus.raddr_b = 12'd7;
    tick();
    check("t3_same_a", bus.dout_a, lane_fill(7));
    check("t3_same_b", bus.dout_b, lane_fill(7));

    // T4: read-during-write on address 10 through both ports.
    bus.write = 1'b1;
    bus.waddr = 12'd10;
    bus.din   = w_aa;
    tick();
    bus.din     = w_55;
    bus.raddr_a = 12'd10;
    bus.raddr_b = 12'd10;
    tick();
`ifdef SRAM_WR_BYPASS_EN
    exp_a = w_55;
`else
    exp_a = w_aa;
`endif
    check("t4_rdw_a", bus.dout_a, exp_a);
    check("t4_rdw_b", bus.dout_b, exp_a);
    bus.write = 1'b0;
    tick();
    check("t4_after_a", bus.dout_a, w_55);
    check("t4_after_b", bus.dout_b, w_55);

    // T5: top and bottom addresses must not alias.
    bus.write = 1'b1;
    bus.waddr = 12'hFFF;
    bus.din   = w_hi;
    tick();
    bus.waddr = 12'h000;
    bus.din   = w_lo;
    tick();
    bus.write   = 1'b0;
    bus.raddr_a = 12'hFFF;
    bus.raddr_b = 12'h000;
    tick();
    check("t5_top_a", bus.dout_a, w_hi);
    check("t5_bot_b", bus.dout_b, w_lo);
    bus.raddr_a = 12'h000;
    bus.raddr_b = 12'hFFF;
    tick();
    check("t5_bot_a", bus.dout_a, w_lo);
    check("t5_top_b", bus.dout_b, w_hi);

    // T6: one-cycle reset during a write to 20, then a normal write to 21.
    rst         = 1'b1;
    bus.write   = 1'b1;
    bus.waddr   = 12'd20;
    bus.din     = ones_w;
    bus.raddr_a = 12'd20;
    bus.raddr_b = 12'd20;
    tick();
    check("t6_rst_a", bus.dout_a, '0);
    check("t6_rst_b", bus.dout_b, '0);
    rst       = 1'b0;
    bus.waddr = 12'd21;
    bus.din   = w_3c;
    tick();
    check("t6_mem20_kept_a", bus.dout_a, lane_fill(20));
    bus.write   = 1'b0;
    bus.raddr_a = 12'd20;
    bus.raddr_b = 12'd21;
    tick();
    check("t6_mem20_kept_b", bus.dout_a, lane_fill(20));
    check("t6_write21", bus.dout_b, w_3c);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
